// File: rtl/miter_bus_sched.sv
// Lockstep bus responder for one channel of the two-core miter. Grants only identical
// requests, answers in order after a fixed latency, and drains/halts on the first mismatch.
module miter_bus_sched #(
  parameter int AddrWidth      = 32,
  parameter int Latency        = 1,
  parameter int MaxOutstanding = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_a_i,
  input  logic                 req_b_i,
  input  logic [AddrWidth-1:0] addr_a_i,
  input  logic [AddrWidth-1:0] addr_b_i,
  input  logic                 we_a_i,
  input  logic                 we_b_i,
  input  logic                 stall_i,
  output logic                 gnt_o,
  output logic                 rvalid_o,
  output logic [2:0]           outstanding_o,
  output logic                 diverge_o,
  output logic [1:0]           diverge_cause_o,
  output logic                 halted_o
);

  typedef enum logic [1:0] {StRun, StDrain, StHalt} state_e;

  state_e               state_q, state_d;
  logic [Latency-1:0]   pipe_q, pipe_d;
  logic [2:0]           outstanding_q, outstanding_d;
  logic                 diverge_q, diverge_d;
  logic [1:0]           cause_q, cause_d;
  logic                 mismatch;
  logic [1:0]           cause;

  // Priority req > addr > we; addresses and we only matter when both cores request.
  always_comb begin
    cause = 2'b00;
    if (req_a_i != req_b_i) begin
      cause = 2'b01;
    end else if (req_a_i && req_b_i && (addr_a_i != addr_b_i)) begin
      cause = 2'b10;
    end else if (req_a_i && req_b_i && (we_a_i != we_b_i)) begin
      cause = 2'b11;
    end
    mismatch = (cause != 2'b00);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StRun;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun:   if (mismatch) state_d = StDrain;
      StDrain: if (outstanding_q == 3'd0) state_d = StHalt;
      StHalt:  state_d = StHalt;
      default: state_d = StRun;
    endcase
  end

  // The slot check uses the registered count, so a same-cycle rvalid never frees a slot.
  always_comb begin
    gnt_o    = rst_ni && (state_q == StRun) && req_a_i && req_b_i && !mismatch && !stall_i &&
               (outstanding_q < 3'(MaxOutstanding));
    halted_o = (state_q == StHalt);
  end

  always_comb begin
    pipe_d    = pipe_q;
    pipe_d[0] = gnt_o;
    for (int i = 1; i < Latency; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
    outstanding_d = outstanding_q + {2'b00, gnt_o} - {2'b00, pipe_q[Latency-1]};
    diverge_d     = diverge_q;
    cause_d       = cause_q;
    if ((state_q == StRun) && mismatch) begin
      diverge_d = 1'b1;
      cause_d   = cause;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pipe_q        <= '0;
      outstanding_q <= 3'd0;
      diverge_q     <= 1'b0;
      cause_q       <= 2'b00;
    end else begin
      pipe_q        <= pipe_d;
      outstanding_q <= outstanding_d;
      diverge_q     <= diverge_d;
      cause_q       <= cause_d;
    end
  end

  assign rvalid_o        = pipe_q[Latency-1];
  assign outstanding_o   = outstanding_q;
  assign diverge_o       = diverge_q;
  assign diverge_cause_o = cause_q;

endmodule
